// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, key/word types, key-schedule FSM states and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NB = 4;
  localparam int AES_NR = 10;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef logic [31:0]           aes_word_t;
  typedef logic [32*AES_NB-1:0]  aes_state_t;
  typedef logic [32*AES_NK-1:0]  aes_key_t;
  typedef logic [3:0]            aes_rnd_idx_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward byte S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = x^254, which is x^-1 for nonzero x and 0 for x = 0.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the byte S-box to each of the four bytes of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word_in,
  output aes_word_t word_out
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    aes_sbox u_sbox (
      .in_byte  (word_in[8*i +: 8]),
      .out_byte (word_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, rounds 0..10.
// Optional round-key store with read port is enabled by defining AES_KEY_STORE_EN.
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_IDX_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [127:0]        key_in,
`ifdef AES_KEY_STORE_EN
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [127:0]        rd_key,
  output logic                store_valid,
`endif
  output logic                busy,
  output logic                rk_valid,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic [127:0]        rk_out,
  output logic                done
);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("aes128_key_expand: NUM_ROUNDS must be 10");
  end

  ks_state_e           state_q, state_d;
  aes_key_t            key_q, key_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [RK_IDX_W-1:0] cnt_q, cnt_d;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_w3, sub_w3, t_word;
  aes_word_t n0, n1, n2, n3;
  logic      last_round;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign last_round = (cnt_q == RK_IDX_W'(NUM_ROUNDS));

  // key_q is both the presented round key and the seed for the next one.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    case (state_q)
      KS_IDLE: begin
        if (start) begin
          state_d = KS_RUN;
          key_d   = key_in;
          rcon_d  = RCON_INIT;
          cnt_d   = '0;
        end
      end
      KS_RUN: begin
        if (last_round) begin
          state_d = KS_IDLE;
        end else begin
          key_d  = {n0, n1, n2, n3};
          rcon_d = xtime(rcon_q);
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      key_q   <= '0;
      rcon_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == KS_RUN);
  assign rk_valid = (state_q == KS_RUN);
  assign rk_idx   = cnt_q;
  assign rk_out   = key_q;
  assign done     = (state_q == KS_RUN) && last_round;

`ifdef AES_KEY_STORE_EN
  localparam int STORE_DEPTH = NUM_ROUNDS + 1;

  aes_key_t store_q [STORE_DEPTH];
  logic     store_valid_q, store_valid_d;
  aes_key_t rd_key_q, rd_key_d;

  // Store contents carry no reset; store_valid gates their meaning.
  always_ff @(posedge clk) begin
    if (state_q == KS_RUN) store_q[cnt_q] <= key_q;
  end

  always_comb begin
    store_valid_d = store_valid_q;
    if (state_q == KS_IDLE && start) store_valid_d = 1'b0;
    else if (done)                   store_valid_d = 1'b1;
    rd_key_d = '0;
    if (rd_idx <= RK_IDX_W'(NUM_ROUNDS)) rd_key_d = store_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_valid_q <= 1'b0;
      rd_key_q      <= '0;
    end else begin
      store_valid_q <= store_valid_d;
      rd_key_q      <= rd_key_d;
    end
  end

  assign store_valid = store_valid_q;
  assign rd_key      = rd_key_q;
`endif

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand against a FIPS-197 style key-expansion model.
// Store checks are compiled in when AES_KEY_STORE_EN is defined.
module tb_aes128_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         store_valid;
`endif

  aes128_key_expand dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
`ifdef AES_KEY_STORE_EN
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
    .store_valid (store_valid),
`endif
    .busy        (busy),
    .rk_valid    (rk_valid),
    .rk_idx      (rk_idx),
    .rk_out      (rk_out),
    .done        (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int           checks   = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] got [11];
  logic [7:0]   sbox_t [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: field arithmetic on plain integers, S-box by inverse search.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p, aa, bb;
    p  = 0;
    aa = int'(a);
    bb = int'(b);
    while (bb != 0) begin
      if ((bb & 1) != 0) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
      bb = bb >> 1;
    end
    return 8'(p);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc   = 8'h01;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]], sbox_t[temp[15:8]], sbox_t[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++)
      exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // Driver: called at a negedge; starts one expansion and checks every round plus the idle cycle after.
  task automatic run_exp(input logic [127:0] key, input bit hold, input int pulse_at, input string tag);
    logic [127:0] exp;
    exp_q.delete();
    push_expected(key);
    key_in = key;
    start  = 1'b1;
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      exp    = exp_q.pop_front();
      got[r] = rk_out;
      chk($sformatf("%s r%0d rk_out", tag, r), rk_out, exp);
      chk($sformatf("%s r%0d rk_idx", tag, r), 128'(rk_idx), 128'(r));
      chk($sformatf("%s r%0d rk_valid", tag, r), 128'(rk_valid), 128'(1));
      chk($sformatf("%s r%0d busy", tag, r), 128'(busy), 128'(1));
      chk($sformatf("%s r%0d done", tag, r), 128'(done), 128'(r == 10));
`ifdef AES_KEY_STORE_EN
      if (r == 0) chk($sformatf("%s store_valid cleared", tag), 128'(store_valid), 128'(0));
`endif
      if (!hold) begin
        start  = (r == pulse_at);
        key_in = (r == pulse_at) ? ~key : key_in;
      end
    end
    @(negedge clk);
    chk($sformatf("%s idle rk_valid", tag), 128'(rk_valid), 128'(0));
    chk($sformatf("%s idle busy", tag), 128'(busy), 128'(0));
    chk($sformatf("%s idle done", tag), 128'(done), 128'(0));
    chk($sformatf("%s idle rk_out hold", tag), rk_out, got[10]);
    chk($sformatf("%s idle rk_idx hold", tag), 128'(rk_idx), 128'(10));
`ifdef AES_KEY_STORE_EN
    chk($sformatf("%s store_valid set", tag), 128'(store_valid), 128'(1));
`endif
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    logic [127:0] rkey;
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
`ifdef AES_KEY_STORE_EN
    rd_idx = '0;
`endif
    build_sbox();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset rk_valid", 128'(rk_valid), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset rk_idx", 128'(rk_idx), 128'(0));
    chk("reset rk_out", rk_out, 128'(0));
`ifdef AES_KEY_STORE_EN
    chk("reset store_valid", 128'(store_valid), 128'(0));
    chk("reset rd_key", rd_key, 128'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key with published round keys
    run_exp(FIPS_KEY, 1'b0, -1, "fips");
    chk("fips known r0", got[0], FIPS_KEY);
    chk("fips known r1", got[1], FIPS_R1);
    chk("fips known r10", got[10], FIPS_R10);
`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd1;
    @(negedge clk);
    chk("store rd_idx1", rd_key, FIPS_R1);
    rd_idx = 4'd15;
    @(negedge clk);
    chk("store rd_idx15", rd_key, 128'(0));
    rd_idx = 4'd10;
    @(negedge clk);
    chk("store rd_idx10", rd_key, FIPS_R10);
    rd_idx = 4'd0;
    @(negedge clk);
    chk("store rd_idx0", rd_key, FIPS_KEY);
`endif

    // All-zero key
    run_exp(128'(0), 1'b0, -1, "zero");
    chk("zero known r1", got[1], ZERO_R1);
    chk("zero known r10", got[10], ZERO_R10);

    // start re-pulsed while busy (sampled at T+3) with a different key
    run_exp(FIPS_KEY, 1'b0, 2, "repulse");
    chk("repulse known r10", got[10], FIPS_R10);
    start = 1'b0;
    @(negedge clk);
    chk("repulse no restart", 128'(busy), 128'(0));

    // Reset in the middle of an expansion
    rkey = {$urandom, $urandom, $urandom, $urandom};
    exp_q.delete();
    push_expected(rkey);
    key_in = rkey;
    start  = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      chk($sformatf("abort r%0d rk_out", r), rk_out, exp_q.pop_front());
      chk($sformatf("abort r%0d done", r), 128'(done), 128'(0));
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort rk_valid", 128'(rk_valid), 128'(0));
    chk("abort rk_out", rk_out, 128'(0));
    chk("abort done", 128'(done), 128'(0));
    chk("abort rk_idx", 128'(rk_idx), 128'(0));
    @(negedge clk);
    chk("abort stays idle", 128'(busy), 128'(0));
    chk("abort no done", 128'(done), 128'(0));
    run_exp(rkey, 1'b0, -1, "after_abort");

    // start held high continuously: second run right after the idle cycle
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_exp(FIPS_KEY, 1'b1, -1, "b2b_first");
    run_exp(rkey, 1'b0, -1, "b2b_second");

    // Randomized keys
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_exp(rkey, 1'b0, -1, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
